// File: rtl/lpgbt_dl_pkg.sv
// lpGBT downlink framer shared definitions: frame fields, idle payload, RS(7,5) generator, GF(8) multiply.
// GF(8) is built on x^3+x+1; the generator g(x) = (x+a)(x+a^2) = x^2 + a^4*x + a^3.
package lpgbt_dl_pkg;

  localparam logic [3:0] HEADER_DEF = 4'b1001;

  localparam int HDR_W     = 4;
  localparam int DATA_W    = 32;
  localparam int EC_W      = 2;
  localparam int IC_W      = 2;
  localparam int PAYLOAD_W = 36;
  localparam int FEC_W     = 24;
  localparam int FRAME_W   = 64;
  localparam int WORD_W    = 32;

  localparam int RS_CW_N     = 4;
  localparam int RS_CW_BITS  = 9;
  localparam int RS_PAR_BITS = 6;
  localparam int RS_SYM_W    = 3;
  localparam int RS_DATA_SYM = 3;
  localparam logic [RS_SYM_W-1:0] RS_G1 = 3'd6;
  localparam logic [RS_SYM_W-1:0] RS_G0 = 3'd3;

  localparam int SCR_TAP = 25;

  typedef struct packed {
    logic [IC_W-1:0]   ic;
    logic [EC_W-1:0]   ec;
    logic [DATA_W-1:0] data;
  } payload_t;

  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic [FEC_W-1:0] fec;
    payload_t         payload;
  } frame_t;

  localparam payload_t IDLE_PAYLOAD = '{ic: 2'b11, ec: 2'b11, data: 32'h0};

  function automatic logic [RS_SYM_W-1:0] gf8_mul(input logic [RS_SYM_W-1:0] a,
                                                  input logic [RS_SYM_W-1:0] b);
    logic [RS_SYM_W-1:0] acc;
    logic [RS_SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < RS_SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[1:0], 1'b0} ^ (sh[2] ? 3'b011 : 3'b000);
    end
    return acc;
  endfunction

endpackage

// File: rtl/lpgbt_dl_rs75_enc.sv
// Four interleaved shortened RS(7,5) encoders: 9 payload bits each -> 2 parity symbols (6 bits each).
// Purely combinational; no latency, no flow control.
module lpgbt_dl_rs75_enc
  import lpgbt_dl_pkg::*;
(
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic [FEC_W-1:0]     o_fec
);

  // The two padding symbols sit at the high-degree end and are zero, so they leave
  // the division register untouched and only the three data symbols are clocked in.
  always_comb begin : enc
    logic [RS_SYM_W-1:0] v_sym;
    logic [RS_SYM_W-1:0] v_fb;
    logic [RS_SYM_W-1:0] v_p0;
    logic [RS_SYM_W-1:0] v_p1;
    o_fec = '0;
    v_sym = '0;
    v_fb  = '0;
    v_p0  = '0;
    v_p1  = '0;
    for (int k = 0; k < RS_CW_N; k++) begin
      v_p0 = '0;
      v_p1 = '0;
      for (int j = RS_DATA_SYM - 1; j >= 0; j--) begin
        v_sym = i_payload[k*RS_CW_BITS + j*RS_SYM_W +: RS_SYM_W];
        v_fb  = v_sym ^ v_p1;
        v_p1  = v_p0 ^ gf8_mul(v_fb, RS_G1);
        v_p0  = gf8_mul(v_fb, RS_G0);
      end
      o_fec[k*RS_PAR_BITS +: RS_PAR_BITS] = {v_p1, v_p0};
    end
  end

endmodule

// File: rtl/lpgbt_dl_tx_framer.sv
// lpGBT downlink TX framer: 36b payload -> scrambler (LPGBT_DL_SCRAMBLER_EN) -> RS FEC -> 64b frame as 2 MGT words.
// Word 0 leaves 1 cycle after accept; user_ready_o only in phase 1 with tx_en_i and mgt_txrdy_i, idle frames fill gaps.
module lpgbt_dl_tx_framer
  import lpgbt_dl_pkg::*;
#(
  parameter logic [HDR_W-1:0] HEADER = HEADER_DEF,
  parameter int               CNT_W  = 16
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              mgt_txrdy_i,
  input  logic              tx_en_i,
  input  logic [DATA_W-1:0] user_data_i,
  input  logic [EC_W-1:0]   user_ec_i,
  input  logic [IC_W-1:0]   user_ic_i,
  input  logic              user_valid_i,
  output logic              user_ready_o,
  output logic [WORD_W-1:0] tx_data_o,
  output logic              tx_frame_start_o,
  output logic [CNT_W-1:0]  frames_sent_o,
  output logic [CNT_W-1:0]  idle_frames_o
);

  logic                 r_phase;
  logic [WORD_W-1:0]    r_word1;
  logic [WORD_W-1:0]    r_tx_data;
  logic                 r_tx_start;
  logic [CNT_W-1:0]     r_frames_sent;
  logic [CNT_W-1:0]     r_idle_frames;

  logic                 w_xfer;
  payload_t             w_payload;
  logic [PAYLOAD_W-1:0] w_scr;
  logic [FEC_W-1:0]     w_fec;
  frame_t               w_frame;

  assign user_ready_o = mgt_txrdy_i & tx_en_i & r_phase;
  assign w_xfer       = user_valid_i & user_ready_o;
  assign w_payload    = w_xfer ? payload_t'({user_ic_i, user_ec_i, user_data_i}) : IDLE_PAYLOAD;

`ifdef LPGBT_DL_SCRAMBLER_EN
  logic [PAYLOAD_W-1:0] r_scr_state;

  // Parallel unroll of y(n)=x(n)^y(n-25)^y(n-36); low bits reach back into the previous frame.
  always_comb begin : scr
    logic [PAYLOAD_W-1:0] v_y;
    v_y = '0;
    for (int i = 0; i < SCR_TAP; i++)
      v_y[i] = w_payload[i] ^ r_scr_state[i] ^ r_scr_state[i + PAYLOAD_W - SCR_TAP];
    for (int i = SCR_TAP; i < PAYLOAD_W; i++)
      v_y[i] = w_payload[i] ^ r_scr_state[i] ^ v_y[i - SCR_TAP];
    w_scr = v_y;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_scr_state <= '0;
    end else if (!mgt_txrdy_i) begin
      r_scr_state <= '0;
    end else if (r_phase) begin
      r_scr_state <= w_scr;
    end
  end
`else
  assign w_scr = w_payload;
`endif

  lpgbt_dl_rs75_enc u_rs_enc (
    .i_payload (w_scr),
    .o_fec     (w_fec)
  );

  assign w_frame = frame_t'({HEADER, w_fec, w_scr});

  // Phase 1 forms a frame and launches word 0; phase 0 launches the stored word 1.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_phase       <= 1'b0;
      r_word1       <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_frames_sent <= '0;
      r_idle_frames <= '0;
    end else if (!mgt_txrdy_i) begin
      r_phase    <= 1'b0;
      r_word1    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        r_word1       <= w_frame[FRAME_W-1:WORD_W];
        r_tx_data     <= w_frame[WORD_W-1:0];
        r_tx_start    <= 1'b1;
        r_frames_sent <= r_frames_sent + CNT_W'(1);
        if (!w_xfer && !(&r_idle_frames)) begin
          r_idle_frames <= r_idle_frames + CNT_W'(1);
        end
      end else begin
        r_tx_data  <= r_word1;
        r_tx_start <= 1'b0;
      end
    end
  end

  assign tx_data_o        = r_tx_data;
  assign tx_frame_start_o = r_tx_start;
  assign frames_sent_o    = r_frames_sent;
  assign idle_frames_o    = r_idle_frames;

endmodule

// File: tb/tb_lpgbt_dl_tx_framer.sv
// Directed bench for lpgbt_dl_tx_framer: vector table plus hand sequences for txrdy drop, async reset, saturation.
`timescale 1ns/1ps
module tb_lpgbt_dl_tx_framer;

  localparam int CNT_W = 8;
  localparam logic [35:0] IDLE_PL = 36'hF_0000_0000;
  localparam logic [35:0] PA = 36'h9_DEAD_BEEF;
  localparam logic [35:0] PB = 36'h3_1234_5678;
  localparam logic [35:0] PC = 36'h6_CAFE_F00D;
  localparam logic [35:0] PD = 36'hC_0F0F_A5A5;

  logic clk = 1'b0;
  logic rst_n, txrdy, tx_en, vld, rdy, sof;
  logic [31:0] udata, txd;
  logic [1:0] uec, uic;
  logic [CNT_W-1:0] fs, idle;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lpgbt_dl_tx_framer #(.CNT_W(CNT_W)) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .mgt_txrdy_i      (txrdy),
    .tx_en_i          (tx_en),
    .user_data_i      (udata),
    .user_ec_i        (uec),
    .user_ic_i        (uic),
    .user_valid_i     (vld),
    .user_ready_o     (rdy),
    .tx_data_o        (txd),
    .tx_frame_start_o (sof),
    .frames_sent_o    (fs),
    .idle_frames_o    (idle)
  );

  typedef struct {
    logic en; logic vld; logic [35:0] pl;
    logic rdy; logic sof; logic [31:0] dat; logic [CNT_W-1:0] fs; logic [CNT_W-1:0] idle;
  } vec_t;

  vec_t tv[17];
  logic [63:0] fr[10];
  logic [63:0] cur;
  int gexp[7];
  int glog[8];
`ifdef LPGBT_DL_SCRAMBLER_EN
  logic [35:0] m_hist;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
`ifdef LPGBT_DL_SCRAMBLER_EN
    m_hist = '0;
`endif
  endtask

  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return 3'(gexp[(glog[a] + glog[b]) % 7]);
  endfunction

  // Long division of m(x)*x^2 by x^2 + 6x + 3, one codeword per 9-bit slice.
  function automatic logic [23:0] fec_model(input logic [35:0] p);
    logic [2:0] c[7];
    logic [2:0] q;
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 7; i++) c[i] = 3'd0;
      for (int j = 0; j < 3; j++) c[j+2] = p[9*k + 3*j +: 3];
      for (int i = 6; i >= 2; i--) begin
        q = c[i];
        c[i] = 3'd0;
        c[i-1] = c[i-1] ^ gmul(q, 3'd6);
        c[i-2] = c[i-2] ^ gmul(q, 3'd3);
      end
      r[6*k +: 6] = {c[1], c[0]};
    end
    return r;
  endfunction

  // Serial scrambler: m_hist[k] holds y(n-1-k).
  function automatic logic [63:0] gold(input logic [35:0] x);
    logic [35:0] y;
    y = x;
`ifdef LPGBT_DL_SCRAMBLER_EN
    for (int i = 0; i < 36; i++) begin
      y[i] = x[i] ^ m_hist[24] ^ m_hist[35];
      m_hist = {m_hist[34:0], y[i]};
    end
`endif
    return {4'b1001, fec_model(y), y};
  endfunction

  function automatic vec_t row(input logic en, input logic v, input logic [35:0] pl,
                               input logic r, input logic s, input logic [31:0] d,
                               input int f, input int i);
    vec_t t;
    t.en = en; t.vld = v; t.pl = pl; t.rdy = r; t.sof = s; t.dat = d;
    t.fs = CNT_W'(f); t.idle = CNT_W'(i);
    return t;
  endfunction

  task automatic step(input logic t, input logic e, input logic v, input logic [35:0] pl);
    @(posedge clk);
    #1;
    txrdy = t; tx_en = e; vld = v;
    {uic, uec, udata} = pl;
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] d, input logic s,
                          input int f, input int i);
    chk({tag, "_dat"}, 64'(txd), 64'(d));
    chk({tag, "_sof"}, 64'(sof), 64'(s));
    chk({tag, "_fs"}, 64'(fs), 64'(CNT_W'(f)));
    chk({tag, "_idle"}, 64'(idle), 64'(CNT_W'(i)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    gexp = '{1, 2, 4, 3, 6, 7, 5};
    for (int i = 0; i < 8; i++) glog[i] = 0;
    for (int i = 0; i < 7; i++) glog[gexp[i]] = i;
    model_reset();

    fr[0] = gold(IDLE_PL); fr[1] = gold(IDLE_PL); fr[2] = gold(PA); fr[3] = gold(PB);
    fr[4] = gold(IDLE_PL); fr[5] = gold(IDLE_PL); fr[6] = gold(PC); fr[7] = gold(IDLE_PL);
    tv[0]  = row(0, 0, 36'h0, 0, 0, 32'h0, 0, 0);
    tv[1]  = row(0, 0, 36'h0, 0, 0, 32'h0, 0, 0);
    tv[2]  = row(0, 0, 36'h0, 0, 1, fr[0][31:0], 1, 1);
    tv[3]  = row(0, 0, 36'h0, 0, 0, fr[0][63:32], 1, 1);
    tv[4]  = row(1, 1, PA, 0, 1, fr[1][31:0], 2, 2);
    tv[5]  = row(1, 1, PA, 1, 0, fr[1][63:32], 2, 2);
    tv[6]  = row(1, 1, PB, 0, 1, fr[2][31:0], 3, 2);
    tv[7]  = row(1, 1, PB, 1, 0, fr[2][63:32], 3, 2);
    tv[8]  = row(0, 1, PB, 0, 1, fr[3][31:0], 4, 2);
    tv[9]  = row(0, 1, PB, 0, 0, fr[3][63:32], 4, 2);
    tv[10] = row(1, 0, PB, 0, 1, fr[4][31:0], 5, 3);
    tv[11] = row(1, 0, PB, 1, 0, fr[4][63:32], 5, 3);
    tv[12] = row(1, 1, PC, 0, 1, fr[5][31:0], 6, 4);
    tv[13] = row(1, 1, PC, 1, 0, fr[5][63:32], 6, 4);
    tv[14] = row(0, 0, 36'h0, 0, 1, fr[6][31:0], 7, 4);
    tv[15] = row(0, 0, 36'h0, 0, 0, fr[6][63:32], 7, 4);
    tv[16] = row(0, 0, 36'h0, 0, 1, fr[7][31:0], 8, 5);
`ifndef LPGBT_DL_SCRAMBLER_EN
    tv[2].dat = 32'h0000_0000;
    tv[3].dat = 32'h9F80_000F;
`endif

    // Reset state with active-looking inputs
    rst_n = 1'b0; txrdy = 1'b1; tx_en = 1'b1; vld = 1'b1; {uic, uec, udata} = PA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(rdy), 64'(0));
    chk_outs("rst", 32'h0, 1'b0, 0, 0);
    txrdy = 1'b0; tx_en = 1'b0; vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(1'b1, tv[i].en, tv[i].vld, tv[i].pl);
      chk($sformatf("v%0d_rdy", i), 64'(rdy), 64'(tv[i].rdy));
      chk_outs($sformatf("v%0d", i), tv[i].dat, tv[i].sof, int'(tv[i].fs), int'(tv[i].idle));
    end

    // txrdy drops during a word-0 cycle for 3 cycles
    step(1, 1, 0, 36'h0);
    fr[8] = gold(IDLE_PL);
    chk("c17_dat", 64'(txd), 64'(fr[7][63:32]));
    step(0, 1, 1, PA);
    chk("drop0_dat", 64'(txd), 64'(fr[8][31:0]));
    chk("drop0_rdy", 64'(rdy), 64'(0));
    step(0, 1, 1, PA);
    chk("drop1_rdy", 64'(rdy), 64'(0));
    chk_outs("drop1", 32'h0, 1'b0, 9, 6);
    step(0, 1, 1, PA);
    chk("drop2_rdy", 64'(rdy), 64'(0));
    chk_outs("drop2", 32'h0, 1'b0, 9, 6);
    model_reset();
    step(1, 1, 1, PD);
    chk("rise0_rdy", 64'(rdy), 64'(0));
    chk_outs("rise0", 32'h0, 1'b0, 9, 6);
    step(1, 1, 1, PD);
    fr[9] = gold(PD);
    chk("rise1_rdy", 64'(rdy), 64'(1));
    chk_outs("rise1", 32'h0, 1'b0, 9, 6);
    step(1, 1, 0, PD);
    chk_outs("rise2", fr[9][31:0], 1'b1, 10, 6);
    step(1, 1, 0, PD);
    chk("rise3_rdy", 64'(rdy), 64'(1));
    chk("rise3_dat", 64'(txd), 64'(fr[9][63:32]));

    // Asynchronous reset mid-frame, checked before the next clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 64'(rdy), 64'(0));
    chk_outs("arst", 32'h0, 1'b0, 0, 0);

    // 100 back-to-back user frames from a fresh reset
    model_reset();
    txrdy = 1'b1; tx_en = 1'b1; vld = 1'b1; {uic, uec, udata} = PA;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc <= 200; cyc++) begin
      if (cyc == 0) begin
        #1 rst_n = 1'b1;
        @(negedge clk);
      end else begin
        step(1, 1, 1, PA);
      end
      chk($sformatf("b%0d_rdy", cyc), 64'(rdy), 64'(cyc % 2));
      if (cyc < 2) begin
        chk($sformatf("b%0d_dat", cyc), 64'(txd), 64'(0));
      end else if (cyc % 2 == 0) begin
        cur = gold(PA);
        chk($sformatf("b%0d_w0", cyc), 64'(txd), 64'(cur[31:0]));
        chk($sformatf("b%0d_sof", cyc), 64'(sof), 64'(1));
      end else begin
        chk($sformatf("b%0d_w1", cyc), 64'(txd), 64'(cur[63:32]));
        chk($sformatf("b%0d_sof", cyc), 64'(sof), 64'(0));
      end
    end
    chk("b_fs100", 64'(fs), 64'(100));
    chk("b_idle0", 64'(idle), 64'(0));

    // Idle-only run past the counter range: idle saturates, frames_sent wraps
    rst_n = 1'b0; tx_en = 1'b0; vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 522; cyc++) begin
      step(1, 0, 0, 36'h0);
      if (cyc == 508) chk("sat508_idle", 64'(idle), 64'(254));
      if (cyc == 510) begin
        chk("sat510_fs", 64'(fs), 64'(255));
        chk("sat510_idle", 64'(idle), 64'(255));
      end
      if (cyc == 512) begin
        chk("sat512_fs", 64'(fs), 64'(0));
        chk("sat512_idle", 64'(idle), 64'(255));
      end
    end
    chk("sat_fs_wrap", 64'(fs), 64'(5));
    chk("sat_idle", 64'(idle), 64'({CNT_W{1'b1}}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
